// File: rtl/thistle_alu_pkg.sv
// Shared definitions for the multibyte ALU sequencer: op codes, FSM state
// encodings and the op-dependent initial carry.
package thistle_alu_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_INC  = 2'b10,
      OP_PASS = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_t;

   // SUB is A + ~B + 1 and INC is A + 0 + 1, so both seed the chain with a carry.
   function automatic logic init_carry(input alu_op_t op);
      logic c;
      c = 1'b0;
      case (op)
         OP_SUB:  c = 1'b1;
         OP_INC:  c = 1'b1;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_multibyte_seq.sv
// Byte-serial driver for an external 8-bit combinational alu: feeds operand
// bytes LSB first, chains the carry and assembles the wide result and flags.
module alu_multibyte_seq
   import thistle_alu_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [8*NBYTES-1:0]   opA,
   input  logic [8*NBYTES-1:0]   opB,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  carryFlag,
   output logic                  zeroFlag,
   output logic [7:0]            aluA,
   output logic [7:0]            aluB,
   output logic                  aluCarryIn,
   output logic                  aluEnB,
   input  logic [7:0]            aluOut,
   input  logic                  aluCarryOut
);

   localparam int W     = ALU_W * NBYTES;
   localparam int CNT_W = $clog2(NBYTES) + 1;

   seq_state_t        state;
   seq_state_t        state_next;
   alu_op_t           op_reg;
   logic [W-1:0]      sh_a;
   logic [W-1:0]      sh_b;
   logic [W-1:0]      res_sh;
   logic [CNT_W-1:0]  byte_idx;
   logic              carry_reg;
   logic              accept;
   logic              last_byte;
   logic [W-1:0]      assembled;

   assign accept    = (state == ST_IDLE) && start;
   assign last_byte = (byte_idx == CNT_W'(NBYTES - 1));

   // Incoming byte lands at the top while earlier bytes slide down, so after
   // NBYTES captures the first (least significant) byte sits at bit 0.
   assign assembled = (res_sh >> ALU_W) | (W'(aluOut) << (W - ALU_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The alu port set is only driven from registered sources in RUN, so the
   // external alu sees stable inputs for the whole cycle.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      aluA       = '0;
      aluB       = '0;
      aluCarryIn = 1'b0;
      aluEnB     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy       = 1'b1;
            aluA       = sh_a[7:0];
            aluB       = (op_reg == OP_SUB) ? ~sh_b[7:0] : sh_b[7:0];
            aluEnB     = (op_reg == OP_ADD) || (op_reg == OP_SUB);
            aluCarryIn = carry_reg;
            if (last_byte) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg    <= OP_ADD;
         sh_a      <= '0;
         sh_b      <= '0;
         res_sh    <= '0;
         byte_idx  <= '0;
         carry_reg <= 1'b0;
         result    <= '0;
         carryFlag <= 1'b0;
         zeroFlag  <= 1'b0;
      end else if (accept) begin
         op_reg    <= alu_op_t'(op);
         sh_a      <= opA;
         sh_b      <= opB;
         byte_idx  <= '0;
         carry_reg <= init_carry(alu_op_t'(op));
      end else if (state == ST_RUN) begin
         res_sh    <= assembled;
         carry_reg <= aluCarryOut;
         sh_a      <= sh_a >> ALU_W;
         sh_b      <= sh_b >> ALU_W;
         byte_idx  <= byte_idx + CNT_W'(1);
         // Carry out of the top byte is reported, never folded into result.
         if (last_byte) begin
            result    <= assembled;
            carryFlag <= aluCarryOut;
            zeroFlag  <= (assembled == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Scoreboard bench for alu_multibyte_seq with a behavioural 8-bit alu wired
// to its alu port set; expected wide results come from a direct W-bit model.
module tb_alu_multibyte_seq;
   import thistle_alu_pkg::*;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic          clk;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  opA;
   logic [W-1:0]  opB;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          carryFlag;
   logic          zeroFlag;
   logic [7:0]    aluA;
   logic [7:0]    aluB;
   logic          aluCarryIn;
   logic          aluEnB;
   logic [7:0]    aluOut;
   logic          aluCarryOut;
   logic [8:0]    alu_sum;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   alu_multibyte_seq #(.NBYTES(NB)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op         (op),
      .opA        (opA),
      .opB        (opB),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .carryFlag  (carryFlag),
      .zeroFlag   (zeroFlag),
      .aluA       (aluA),
      .aluB       (aluB),
      .aluCarryIn (aluCarryIn),
      .aluEnB     (aluEnB),
      .aluOut     (aluOut),
      .aluCarryOut(aluCarryOut)
   );

   // Behavioural 8-bit alu: a + (en_b ? b : 0) + carryIn.
   assign alu_sum     = {1'b0, aluA} + (aluEnB ? {1'b0, aluB} : 9'd0) + {8'd0, aluCarryIn};
   assign aluOut      = alu_sum[7:0];
   assign aluCarryOut = alu_sum[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t       e;
      logic [W:0] s;
      case (o)
         OP_ADD:  s = {1'b0, a} + {1'b0, b};
         OP_SUB:  s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         OP_INC:  s = {1'b0, a} + (W+1)'(1);
         default: s = {1'b0, a};
      endcase
      e.res = s[W-1:0];
      e.c   = s[W];
      e.z   = (s[W-1:0] == '0);
      return e;
   endfunction

   // Any done pulse retires the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", result, e.res);
            checkOutput("carryFlag", carryFlag, e.c);
            checkOutput("zeroFlag", zeroFlag, e.z);
            checkOutput("busy_in_done", busy, 1);
         end
      end
   end

   // Called at a negedge; returns one negedge later with start dropped.
   task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      op    = o;
      opA   = a;
      opB   = b;
      sb.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit check_enb);
      int n;
      applyStimulus(o, a, b);
      n = 1;
      while (!done && n < 20) begin
         if (check_enb && busy) checkOutput("inc_enb", aluEnB, 0);
         @(negedge clk);
         n++;
      end
      checkOutput("done_latency", n, 5);
      @(negedge clk);
      checkOutput("done_pulse", done, 0);
      checkOutput("idle_busy", busy, 0);
   endtask

   initial begin
      int   pulses;
      int   first_done;
      int   second_done;
      bit   saw_done;
      exp_t dropped;

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      opA   = '0;
      opB   = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_carry", carryFlag, 0);
      checkOutput("rst_zero", zeroFlag, 0);
      checkOutput("rst_aluA", aluA, 0);
      checkOutput("rst_aluB", aluB, 0);
      checkOutput("rst_aluCin", aluCarryIn, 0);
      checkOutput("rst_aluEnB", aluEnB, 0);
      rst = 1'b0;
      @(negedge clk);

      runOp(OP_ADD,  32'h0000_00FF, 32'h0000_0001, 1'b0);
      runOp(OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      runOp(OP_SUB,  32'h0000_0005, 32'h0000_0003, 1'b0);
      runOp(OP_SUB,  32'h0000_0003, 32'h0000_0005, 1'b0);
      runOp(OP_INC,  32'h00FF_FFFF, 32'hDEAD_BEEF, 1'b1);
      runOp(OP_PASS, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("result_hold", result, 32'h1234_5678);
      checkOutput("idle_aluA", aluA, 0);
      checkOutput("idle_aluEnB", aluEnB, 0);

      // start held high through RUN/DONE while operands churn.
      start = 1'b1;
      op    = OP_ADD;
      opA   = 32'h0000_0001;
      opB   = 32'h0000_0002;
      sb.push_back(model(OP_ADD, 32'h0000_0001, 32'h0000_0002));
      pulses      = 0;
      first_done  = 0;
      second_done = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            if (first_done == 0) first_done = i;
            else second_done = i;
         end
         if (i < 5) begin
            op  = OP_SUB;
            opA = $urandom;
            opB = $urandom;
         end
         if (i == 5) begin
            op  = OP_ADD;
            opA = 32'h0000_000A;
            opB = 32'h0000_0014;
            sb.push_back(model(OP_ADD, 32'h0000_000A, 32'h0000_0014));
         end
         if (i == 6) checkOutput("hold_idle_gap", busy, 0);
         if (i == 7) start = 1'b0;
      end
      checkOutput("hold_pulses", pulses, 2);
      checkOutput("hold_first_done", first_done, 5);
      checkOutput("hold_second_done", second_done, 11);

      // Reset while driving byte 2 of an in-flight ADD.
      applyStimulus(OP_ADD, 32'h0102_0304, 32'h1020_3040);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dropped = sb.pop_back();
      @(negedge clk);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_result", result, 0);
      checkOutput("midrst_carry", carryFlag, 0);
      checkOutput("midrst_zero", zeroFlag, 0);
      checkOutput("midrst_aluA", aluA, 0);
      checkOutput("midrst_aluEnB", aluEnB, 0);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checkOutput("midrst_no_done", saw_done, 0);

      runOp(OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
